dispatcher_cpuid_mgr: RTL
=========================

# dispatcher_cpuid_mgr

CPUID manage block: responder side of the dispatcher's CPUID request handshake. It samples a request level (`in_cpuid_ctl` plus a 5-bit key) and grants a CPU thread id, round-robin over enabled, non-saturated threads. It tracks outstanding packets per thread and refuses grants (`valid=0`) when no thread can accept more. It sits between the dispatcher input stage and the PPC subsystem, which returns thread releases.

## Interface
- `NUM_THREADS`, default 8: number of thread ids; legal range 1..32. Grantable ids are 0..NUM_THREADS-1.
- `MAX_PENDING`, default 4: maximum outstanding packets per thread; legal range 1..(2^CNT_W - 1).
- `CNT_W`, default 3: width of the per-thread outstanding counter.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_cpuid_ctl` in 1: request level from the dispatcher.
- `in_cpuid_key` in 5: request key (inport, offset by slot).
- `out_cpuid` out 5: granted thread id.
- `out_cpuid_ack` out 1: grant outputs are valid and held.
- `out_cpuid_valid` out 1: 1 = grant committed; 0 = refuse, requester must discard.
- `in_release_wr` in 1: PPC has finished one packet of a thread.
- `in_release_cpuid` in 5: thread id being released.
- `in_thread_en` in NUM_THREADS: per-thread enable, sampled every cycle.
- `out_release_err` out 1: sticky flag; set on a release to a zero counter or an id ≥ NUM_THREADS.

## Operation
- State: `cnt[i]` (CNT_W bits per thread), `rr_ptr` (5 bits, mod NUM_THREADS), FSM {IDLE, GRANT}.
- Eligible thread i: `in_thread_en[i]=1` and `cnt[i] < MAX_PENDING`.
- Selection: first eligible i searched from `rr_ptr` upward, wrapping. The search is combinational over one cycle.
- IDLE with `in_cpuid_ctl=1`, at that edge:
  - If an eligible thread exists: `out_cpuid` = selected id, `out_cpuid_valid=1`, `cnt[sel]+1`, `rr_ptr` = (sel+1) mod NUM_THREADS.
  - If none: `out_cpuid=0`, `out_cpuid_valid=0`, no counter change, `rr_ptr` unchanged.
  - In both cases `out_cpuid_ack=1`; go to GRANT.
- GRANT: `out_cpuid`, `out_cpuid_ack`, `out_cpuid_valid` are held constant while `in_cpuid_ctl=1`. The key is ignored.
- GRANT with `in_cpuid_ctl=0`, at that edge: ack, valid and cpuid clear to 0; return to IDLE.
- Protocol rule: the requester drops ctl for at least 1 cycle between requests. Each request produces exactly one grant.
- Release on `in_release_wr=1` with a valid id:
  - `cnt[id]>0`: decrement.
  - `cnt[id]=0`: counter unchanged, set `out_release_err`.
  - id ≥ NUM_THREADS: set `out_release_err`, no counter change.
- Simultaneous grant and release to the same thread: net counter change 0. The eligibility check uses the pre-edge count.
- Disabling a thread does not clear its counter; releases still decrement it.
- `out_release_err` clears only on reset.

## Timing
- Reset values: all outputs 0, all counters 0, `rr_ptr=0`, FSM in IDLE.
- Latency: ctl first sampled high at edge T, so ack, valid and cpuid are registered at T. They are visible the cycle after the request cycle.
- Ack deasserts on the edge that samples ctl low; a new request is accepted at the earliest one cycle later.
- Release latency is 1 edge. A grant's eligibility sees a release only from the following request.
- Reset asserted mid-GRANT: outputs clear at the next edge. A ctl still high after reset deasserts is treated as a new request.

## Configuration
- `CPUID_HASH_EN` defined: selection is static, sel = `in_cpuid_key` mod NUM_THREADS.
  - valid=1 only if that thread is eligible; otherwise valid=0 and `out_cpuid`=sel.
  - No search; `rr_ptr` is unused and held at 0.
- Not defined: round-robin search as described in Operation.

## Test plan
- Round-robin: after reset, 9 requests with all threads enabled and no releases.
  - Expected ids 0,1,…,7,0 with valid=1; each ack arrives 1 cycle after ctl rises; cnt[0]=2.
- Saturation: MAX_PENDING=4 with only thread 3 enabled; 5 requests.
  - First 4 grant id 3 with valid=1; the 5th returns ack=1, valid=0, cpuid=0.
  - One release of id 3, then a further request: grant id 3, valid=1.
- Hold: ctl held high for 6 cycles while the key changes.
  - Outputs stay constant; ack drops 1 cycle after ctl falls.
- Simultaneous events: grant of thread 2 and release of thread 2 on the same edge with cnt[2]=1 → cnt[2] remains 1.
  - Release to a zero counter → `out_release_err=1`, which stays set until reset.
- Reset mid-grant: reset asserted during GRANT with ctl held high.
  - Outputs become 0; after deassert, a new grant of id 0 with all counters at 0.
- `CPUID_HASH_EN` build: key 13 with NUM_THREADS=8 → cpuid 5.
  - With thread 5 disabled → valid=0, cpuid=5.

Source files
------------

// File: rtl/dispatcher_cpuid_if.sv
// Dispatcher <-> CPUID manager request/grant handshake.
interface dispatcher_cpuid_if;
  logic       in_cpuid_ctl;
  logic [4:0] in_cpuid_key;
  logic [4:0] out_cpuid;
  logic       out_cpuid_ack;
  logic       out_cpuid_valid;

  modport master (
    output in_cpuid_ctl, in_cpuid_key,
    input  out_cpuid, out_cpuid_ack, out_cpuid_valid
  );
  modport slave (
    input  in_cpuid_ctl, in_cpuid_key,
    output out_cpuid, out_cpuid_ack, out_cpuid_valid
  );
endinterface

// File: rtl/dispatcher_cpuid_mgr.sv
// CPUID manager: grants thread ids round-robin over enabled, non-saturated threads.
// Define CPUID_HASH_EN for static selection (key mod NUM_THREADS) instead of round-robin.

module dispatcher_cpuid_cnt #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             elig,
  output logic             zero
);
  logic dec_ok;

  assign zero   = (cnt == '0);
  assign elig   = en && (cnt < CNT_W'(MAX_PENDING));
  // a release to an empty counter is dropped; the top flags it as an error
  assign dec_ok = dec && !zero;

  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (inc && !dec_ok) cnt <= cnt + 1'b1;
    else if (dec_ok && !inc) cnt <= cnt - 1'b1;
  end
endmodule

module dispatcher_cpuid_mgr #(
  parameter int NUM_THREADS = 8,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  dispatcher_cpuid_if.slave      req,
  input  logic                   in_release_wr,
  input  logic [4:0]             in_release_cpuid,
  input  logic [NUM_THREADS-1:0] in_thread_en,
  output logic                   out_release_err
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;

  logic [NUM_THREADS-1:0][CNT_W-1:0] cnt;
  logic [NUM_THREADS-1:0] elig, zero, inc, dec;
  logic [4:0] rr_ptr, sel;
  logic       found, take, rel_err, unused_sig;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
    dispatcher_cpuid_cnt #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) u_cnt (
      .clk(clk), .reset(reset), .en(in_thread_en[g]),
      .inc(inc[g]), .dec(dec[g]),
      .cnt(cnt[g]), .elig(elig[g]), .zero(zero[g])
    );
    assign inc[g] = take && found && (sel == 5'(g));
    assign dec[g] = in_release_wr && (in_release_cpuid == 5'(g));
  end

  assign rel_err = in_release_wr &&
                   ((32'(in_release_cpuid) >= NUM_THREADS) || (|(dec & zero)));

`ifdef CPUID_HASH_EN
  always_comb begin
    sel   = 5'(32'(req.in_cpuid_key) % NUM_THREADS);
    found = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++)
      if (sel == 5'(i)) found = elig[i];
  end

  always_ff @(posedge clk) rr_ptr <= '0;

  assign unused_sig = ^rr_ptr;
`else
  logic [4:0] sel_hi, sel_lo;
  logic       found_hi, found_lo;

  // descending scan leaves the lowest eligible id at/above rr_ptr, else the lowest below it
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (5'(i) >= rr_ptr) begin found_hi = 1'b1; sel_hi = 5'(i); end
        else                 begin found_lo = 1'b1; sel_lo = 5'(i); end
      end
    end
    found = found_hi | found_lo;
    sel   = found_hi ? sel_hi : sel_lo;
  end

  always_ff @(posedge clk) begin
    if (reset)              rr_ptr <= '0;
    else if (take && found) rr_ptr <= (sel == 5'(NUM_THREADS - 1)) ? 5'd0 : sel + 5'd1;
  end

  assign unused_sig = ^req.in_cpuid_key;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      IDLE:    if (req.in_cpuid_ctl) begin take = 1'b1; state_nx = GRANT; end
      GRANT:   if (!req.in_cpuid_ctl) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req.out_cpuid       <= '0;
      req.out_cpuid_ack   <= 1'b0;
      req.out_cpuid_valid <= 1'b0;
      out_release_err     <= 1'b0;
    end else begin
      if (take) begin
`ifdef CPUID_HASH_EN
        req.out_cpuid     <= sel;
`else
        req.out_cpuid     <= found ? sel : 5'd0;
`endif
        req.out_cpuid_ack   <= 1'b1;
        req.out_cpuid_valid <= found;
      end else if (state == GRANT && !req.in_cpuid_ctl) begin
        req.out_cpuid       <= '0;
        req.out_cpuid_ack   <= 1'b0;
        req.out_cpuid_valid <= 1'b0;
      end
      if (rel_err) out_release_err <= 1'b1;
    end
  end
endmodule
